// File: rtl/sseg_scan_driver.sv
// Multi-digit seven-segment scan driver with double-buffered digit data,
// leading-zero suppression and selectable output polarity.
module sseg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic                    enable,
    output logic [7:0]              sseg_cathode,
    output logic [NUM_DIGITS-1:0]   sseg_anode,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            CATH_OFF = {8{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIG_W-1:0]      sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic [DIG_W-1:0]      act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic [7:0]            cath_q, cath_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end_c;
    logic                  frame_end_c;
    logic [NUM_DIGITS-1:0] lz_supp_c;
    logic [3:0]            cur_nib_c;
    logic                  cur_dp_c;
    logic                  cur_blank_c;
    logic                  cur_supp_c;
    logic [7:0]            seg_n_c;
    logic [NUM_DIGITS-1:0] anode_n_c;

    // Active-low hex glyphs, DP (bit7) off.
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Scan timing and tear-free shadow -> active transfer at the frame boundary.
    always_comb begin
        slot_end_c   = (cnt_q == CNT_MAX);
        frame_end_c  = slot_end_c && (idx_q == IDX_MAX);
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        sh_dig_d     = sh_dig_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        act_dig_d    = act_dig_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        frame_done_d = frame_end_c;

        if (slot_end_c) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            sh_dig_d   = digits_in;
            sh_dp_d    = dp_in;
            sh_blank_d = blank_in;
        end

        // A load coinciding with the boundary bypasses the shadow so it shows immediately.
        if (frame_end_c) begin
            act_dig_d   = sh_dig_d;
            act_dp_d    = sh_dp_d;
            act_blank_d = sh_blank_d;
        end
    end

    // Leading-zero chain: lead stays set while every higher digit is zero or blanked.
    always_comb begin : lz_chain
        logic lead;
        lead      = 1'b1;
        lz_supp_c = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            lz_supp_c[k] = lz_suppress && (k != 0) && lead
                           && (act_dig_q[4*k +: 4] == 4'h0);
            lead = lead && ((act_dig_q[4*k +: 4] == 4'h0) || act_blank_q[k]);
        end
    end

    always_comb begin
        cur_nib_c   = 4'h0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        cur_supp_c  = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib_c   = act_dig_q[4*k +: 4];
                cur_dp_c    = act_dp_q[k];
                cur_blank_c = act_blank_q[k];
                cur_supp_c  = lz_supp_c[k];
            end
        end
    end

    // Build the lit pattern in active-low form, then apply board polarity.
    always_comb begin
        seg_n_c    = seg_decode(cur_nib_c);
        seg_n_c[7] = ~cur_dp_c;
        if (!enable || cur_blank_c) begin
            seg_n_c = 8'hFF;
        end else if (cur_supp_c) begin
            seg_n_c = {~cur_dp_c, 7'h7F};
        end
        anode_n_c = enable ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        cath_d    = ACTIVE_LOW ? seg_n_c : ~seg_n_c;
        anode_d   = ACTIVE_LOW ? anode_n_c : ~anode_n_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_dig_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            cath_q       <= CATH_OFF;
            anode_q      <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_dig_q     <= sh_dig_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            cath_q       <= cath_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sseg_cathode = cath_q;
    assign sseg_anode   = anode_q;
    assign frame_done   = frame_done_q;

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Parametrised multi-digit seven-segment scan driver: holds NUM_DIGITS hex nibbles plus per-digit decimal-point and blank flags, time-multiplexes them onto a shared cathode bus and one-hot anode bus. It adds tear-free double-buffered loading, leading-zero suppression and selectable output polarity. It sits between the counter/BCD logic and the board's seven-segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2)
ACTIVE_LOW, 1, 1 = anodes and cathodes active-low (board default); 0 = both active-high

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe; captures digits_in/dp_in/blank_in into shadow registers
digits_in  input  4*NUM_DIGITS  hex nibbles; bits [3:0] = digit 0 (rightmost)
dp_in  input  NUM_DIGITS  decimal point on per digit
blank_in  input  NUM_DIGITS  force digit dark
lz_suppress  input  1  enable leading-zero blanking
enable  input  1  0 = all digits dark; scan keeps running
sseg_cathode  output  8  bit7 = DP, bits[6:0] = segments g..a
sseg_anode  output  NUM_DIGITS  digit select, one-hot in active polarity
frame_done  output  1  one-cycle pulse after last digit slot of each frame

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: refresh counter 0, scan index 0, shadow and active registers 0, frame_done 0, sseg_anode all off, sseg_cathode all off (0xFF when ACTIVE_LOW=1, 0x00 otherwise). Reset mid-frame aborts the frame; no frame_done is issued.
- Refresh counter cnt: 0..REFRESH_DIV-1, increments every cycle. At cnt==REFRESH_DIV-1, cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary: cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1. On that edge the active registers are loaded from shadow. If load is high on the same cycle, the load inputs go directly to active (bypass) and to shadow. frame_done is high for the cycle after the boundary.
- load: shadow is updated on every load; with multiple loads in one frame, the last one wins. Displayed data changes only at frame boundaries (no tearing).
- Output pipeline: sseg_anode and sseg_cathode are registered from (idx, active, enable, lz_suppress), giving 1-cycle latency. Each digit is lit for exactly REFRESH_DIV cycles. After reset release, digit 0 outputs appear on the first cycle.
- Decode (active-low g..a, DP bit7 = 1 when off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E. DP on clears bit7. ACTIVE_LOW=0 inverts cathode and anode buses.
- Blanking: a digit is dark (cathodes all off, anode still asserted) if blank_in[k], or if !enable, or by leading-zero suppression. When enable=0, anodes are also all off.
- Leading-zero suppression (lz_suppress=1): digit k is blanked if its nibble is 0 and all higher digits are 0 or blanked. Digit 0 is never suppressed. A suppressed digit whose DP is set still shows the DP. Evaluation uses active registers only.
- Width rules: counter width = clog2(REFRESH_DIV); idx width = max(1, clog2(NUM_DIGITS)).

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4, reset 3 cycles -> anode=1111, cathode=FF. Release reset -> anode 1110 for exactly 4 cycles, then 1101, 1011, 0111. frame_done pulses once every 16 cycles.
- load digits_in=0x12AF, dp_in=0001 mid-frame -> old data is held until the boundary. Next frame shows digit0 8E with DP cleared = 0E, digit1 88, digit2 A4, digit3 F9.
- lz_suppress=1, digits_in=0x0030 -> digit3 and digit2 dark (FF), digit1 B0, digit0 C0. Same stimulus with digits_in=0x0000 -> only digit0 shows C0.
- load and frame boundary coincide (digits_in=0x8888) -> 0x8888 is shown in the frame that starts immediately, with no one-frame delay.
- enable=0 mid-scan -> anode=1111 on the next cycle and idx keeps advancing. Re-enable -> scan resumes on the correct digit slot without a restart.
- ACTIVE_LOW=0, digits_in=0x0001 -> digit0 cathode=0x06 and anode is one-hot high. Reset asserted mid-frame -> outputs go all off next cycle and no frame_done is issued.
